// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_hazard_ctrl                                                         |
// | Stall/flush sequencer for the 16-bit 5-stage pipeline, with a            |
// | saturating stall-cycle counter.                                          |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module pipe_hazard_ctrl #(
  parameter int MD_CYCLES = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idValid,
  input  logic [3:0]       idRs1,
  input  logic [3:0]       idRs2,
  input  logic             idUse1,
  input  logic             idUse2,
  input  logic [3:0]       exRd,
  input  logic             exMemRead,
  input  logic             mdStart,
  input  logic             branchTaken,
  input  logic             memWait,
  input  logic             clrStats,
  output logic             pcWrite,
  output logic             ifidWrite,
  output logic             idexWrite,
  output logic             exmemWrite,
  output logic             memwbWrite,
  output logic             ifidFlush,
  output logic             idexFlush,
  output logic             exmemFlush,
  output logic             mdBusy,
  output logic [CNT_W-1:0] stallCount
);

  localparam logic [0:0]       c_RUN     = 1'b0;
  localparam logic [0:0]       c_MDWAIT  = 1'b1;
  localparam logic [3:0]       c_MD_LAST = 4'(MD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [0:0]       r_state;
  logic [3:0]       r_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic w_load_use;
  logic w_md_stall;

  assign w_load_use = idValid & exMemRead &
                      ((idUse1 & (idRs1 == exRd)) | (idUse2 & (idRs2 == exRd)));

  // EX is held by mul/div on the start cycle and every MDWAIT cycle except the release.
  assign w_md_stall = ((r_state == c_RUN) & mdStart) |
                      ((r_state == c_MDWAIT) & (r_cnt != 4'd0));

  always_comb begin
    pcWrite    = 1'b1;
    ifidWrite  = 1'b1;
    idexWrite  = 1'b1;
    exmemWrite = 1'b1;
    memwbWrite = 1'b1;
    ifidFlush  = 1'b0;
    idexFlush  = 1'b0;
    exmemFlush = 1'b0;
    mdBusy     = 1'b0;
    if (reset) begin
      mdBusy = w_md_stall;
      if (memWait) begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexWrite  = 1'b0;
        exmemWrite = 1'b0;
        memwbWrite = 1'b0;
      end else if (w_md_stall) begin
        pcWrite    = 1'b0;
        ifidWrite  = 1'b0;
        idexWrite  = 1'b0;
        exmemFlush = 1'b1;
      end else if (r_state == c_MDWAIT) begin
        // Release cycle: defaults let the mul/div result move on.
      end else if (branchTaken) begin
        ifidFlush = 1'b1;
        idexFlush = 1'b1;
      end else if (w_load_use) begin
        pcWrite   = 1'b0;
        ifidWrite = 1'b0;
        idexFlush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= c_RUN;
      r_cnt       <= 4'd0;
      r_stall_cnt <= '0;
    end else begin
      if (!memWait) begin
        case (r_state)
          c_RUN: begin
            if (mdStart) begin
              r_state <= c_MDWAIT;
              r_cnt   <= c_MD_LAST;
            end
          end
          c_MDWAIT: begin
            if (r_cnt != 4'd0) begin
              r_cnt <= r_cnt - 4'd1;
            end else begin
              r_state <= c_RUN;
            end
          end
          default: r_state <= c_RUN;
        endcase
      end
      if (clrStats) begin
        r_stall_cnt <= '0;
      end else if (!pcWrite && (r_stall_cnt != c_CNT_MAX)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign stallCount = r_stall_cnt;

endmodule
`default_nettype wire
